dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Initiator-side controller for the word-addressed data memory (async read, sync write, 32-bit words).
- Accepts byte-addressed load/store requests from the CPU datapath and drives memory Address/WriteData/MemWrite/MemRead.
- Byte/halfword stores are performed as read-modify-write. Load data is lane-extracted and sign- or zero-extended.
- Misaligned, reserved-size and out-of-range requests are reported without touching memory.

Parameters:
- ADDR_WIDTH, 8, log2 of memory depth in words; must match the data memory instance.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1 = store, 0 = load
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; right-aligned for byte/half
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = rejected request
- rdata  out  32  load result; valid with done
- Address  out  32  word index to memory
- WriteData  out  32  word to memory
- MemWrite  out  1  memory write enable
- MemRead  out  1  memory read enable
- ReadData  in  32  memory read data (combinational from Address/MemRead)

Behaviour:
- Reset (synchronous): state=IDLE; busy, done, err = 0; rdata = 0; Address, WriteData = 0; MemWrite, MemRead = 0.
- States: IDLE, LOAD, RMW_RD, RMW_WR, ST_WR, RESP.
- Memory-side outputs are combinational from state and captured registers.
  - In IDLE and RESP: MemRead=0, MemWrite=0, Address=0, WriteData=0.
  - Otherwise: Address = {2'b00, addr_q[31:2]}.
- IDLE:
  - On req=1, capture we, size, sign_ext, addr, wdata.
  - Validity check on the captured request:
    - size=11 → err.
    - half with addr[0]=1 → err.
    - word with addr[1:0]≠0 → err.
    - addr[31:2] ≥ 2**ADDR_WIDTH → err.
  - Invalid: go to RESP with err=1; no memory access.
  - Valid load: go to LOAD.
  - Valid word store: go to ST_WR.
  - Valid byte/half store: go to RMW_RD.
- busy = 1 in every state except IDLE. req is ignored while busy=1; it is not queued.
- LOAD:
  - MemRead=1.
  - At the clock edge, register the extracted ReadData lane into rdata. Go to RESP.
- RMW_RD:
  - MemRead=1.
  - At the clock edge, register merge = ReadData with the target lane replaced by wdata_q[7:0] or [15:0]. Go to RMW_WR.
- RMW_WR: MemWrite=1, WriteData=merge. Go to RESP.
- ST_WR: MemWrite=1, WriteData=wdata_q. Go to RESP.
- RESP:
  - done=1 for exactly one cycle; err as determined. Return to IDLE.
  - A new req can be accepted in the cycle after RESP.
- Latency, counted from the req-sampling edge to the cycle in which done is high:
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Byte/half store: 3 cycles.
- Lane rules (little-endian):
  - Byte lane k = addr[1:0] occupies bits 8k+7:8k.
  - Half lane at addr[1]=0 is bits 15:0; at addr[1]=1 it is bits 31:16.
- Extension:
  - Byte load: sign_ext=1 replicates bit 7 into bits 31:8; else zeros.
  - Half load: sign_ext=1 replicates bit 15 into bits 31:16; else zeros.
  - Word load: no extension.
- rdata holds its last value until the next load completes. Stores and errors do not change rdata.
- Reset mid-operation: forces IDLE with no done pulse.
  - If reset is sampled in ST_WR or RMW_WR, the memory also samples MemWrite=1 at that edge and the write takes effect.
  - In every other state, memory contents are unchanged.
- Highest valid address is 4*(2**ADDR_WIDTH)-1. With the default this is 0x3FF; 0x400 → err.

Test Plan:
- Reset, then idle 3 cycles → busy=0, done=0, MemRead=0, MemWrite=0, Address=0.
- Word store addr=0x10, wdata=0xDEADBEEF; then word load addr=0x10:
  - Store: MemWrite=1 with Address=4 one cycle; done 2 cycles after req.
  - Load: rdata=0xDEADBEEF, err=0.
- Memory word 4 = 0x11223344; store byte addr=0x12, wdata=0xAA:
  - One MemRead cycle, then one MemWrite cycle with WriteData=0x11AA3344; done at cycle 3.
- Memory word 4 = 0x80FF7F01:
  - lb addr=0x13, sign_ext=1 → rdata=0xFFFFFF80.
  - lbu addr=0x13 → 0x00000080.
  - lh addr=0x12, sign_ext=1 → 0xFFFF80FF.
  - lhu addr=0x10 → 0x00007F01.
- Error cases, each → done with err=1 one cycle after req, no MemRead/MemWrite, rdata unchanged:
  - Word load addr=0x11.
  - Half store addr=0x13.
  - size=11.
  - Word load addr=0x400.
- Two protocol checks:
  - Pulse req during busy of an RMW store → second request ignored, exactly one done.
  - Assert reset in RMW_WR → no done, word written, FSM returns to IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
//-----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Initiator-side controller between the CPU datapath and a word-addressed data
// memory (asynchronous read, synchronous write, 32-bit words). It takes
// byte-addressed load/store requests and turns them into word accesses:
//   - word stores are written directly,
//   - byte/half stores are done as read-modify-write of the containing word,
//   - loads extract the addressed lane and sign- or zero-extend it,
//   - misaligned, reserved-size and out-of-range requests complete with err=1
//     and never touch memory.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req                 request strobe, sampled only while busy=0
//   we                  1 = store, 0 = load
//   size                00 byte, 01 half, 10 word, 11 reserved
//   sign_ext            loads only: 1 = sign-extend, 0 = zero-extend
//   addr, wdata         byte address, right-aligned store data
//   busy                high while a request is in progress
//   done, err, rdata    one-cycle completion pulse, error flag, load result
//   Address, WriteData  word index and write word to memory
//   MemWrite, MemRead   memory strobes
//   ReadData            memory read data (combinational from Address/MemRead)
//-----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] ReadData
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        RMW_WR,
        ST_WR,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Number of words in the memory; compared against the 30-bit word index
    // with one extra bit so ADDR_WIDTH=30 still works.
    localparam logic [30:0] DEPTH_WORDS = 31'(1) << ADDR_WIDTH;

    state_t      state, state_next;
    logic [1:0]  size_q;
    logic        sign_ext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        err_q;
    logic        req_bad;

    // Lane extraction with extension for loads (little-endian lanes).
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  lo,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: return {{24{sx & b[7]}}, b};
            SZ_HALF: return {{16{sx & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace the target lane of the word read back with the store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  lo,
        input logic [31:0] data
    );
        logic [31:0] m;
        m = word;
        if (sz == SZ_BYTE) begin
            m[{lo, 3'b000} +: 8] = data[7:0];
        end else if (lo[1]) begin
            m[31:16] = data[15:0];
        end else begin
            m[15:0] = data[15:0];
        end
        return m;
    endfunction

    // Validity check evaluated on the request as it is captured; the result
    // is registered in err_q on the same edge that captures the fields.
    always_comb begin
        case (size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = addr[0];
            SZ_WORD: req_bad = |addr[1:0];
            default: req_bad = 1'b1;
        endcase
        if ({1'b0, addr[31:2]} >= DEPTH_WORDS) begin
            req_bad = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            size_q     <= '0;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            err_q      <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                size_q     <= size;
                sign_ext_q <= sign_ext;
                addr_q     <= addr;
                wdata_q    <= wdata;
                err_q      <= req_bad;
            end
            // rdata only moves on a completed load; stores and errors keep it.
            if (state == LOAD) begin
                rdata <= load_extract(ReadData, size_q, addr_q[1:0], sign_ext_q);
            end
            if (state == RMW_RD) begin
                merge_q <= store_merge(ReadData, size_q, addr_q[1:0], wdata_q);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        WriteData  = '0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (req_bad) begin
                        state_next = RESP;
                    end else if (!we) begin
                        state_next = LOAD;
                    end else if (size == SZ_WORD) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LOAD: begin
                MemRead    = 1'b1;
                Address    = {2'b00, addr_q[31:2]};
                state_next = RESP;
            end
            RMW_RD: begin
                MemRead    = 1'b1;
                Address    = {2'b00, addr_q[31:2]};
                state_next = RMW_WR;
            end
            RMW_WR: begin
                MemWrite   = 1'b1;
                Address    = {2'b00, addr_q[31:2]};
                WriteData  = merge_q;
                state_next = RESP;
            end
            ST_WR: begin
                MemWrite   = 1'b1;
                Address    = {2'b00, addr_q[31:2]};
                WriteData  = wdata_q;
                state_next = RESP;
            end
            RESP: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
//-----------------------------------------------------------------------------
// Testbench for dmem_access_ctrl. A behavioural data memory serves the DUT;
// a separate reference copy of memory plus a small load/store model produce
// expected results, which are queued when a request is driven and compared
// when done is seen.
//-----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    dmem_access_ctrl #(.ADDR_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory seen by the DUT, with a backdoor port for preloading.
    logic [31:0] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clock) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (MemWrite) mem[Address[7:0]] <= WriteData;
    end
    assign ReadData = MemRead ? mem[Address[7:0]] : 32'h0;

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wword;
        logic [31:0] widx;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic m_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'h400);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] a, input logic sx);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(a[1:0]);
        case (sz)
            2'b00: begin
                v = (w >> sh) & 32'h0000_00FF;
                if (sx && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (w >> sh) & 32'h0000_FFFF;
                if (sx && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh   = 8 * int'(a[1:0]);
        mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic bd_write(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clock);
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        ref_mem[idx] = d;
        @(negedge clock);
        bd_we = 1'b0;
    endtask

    // Drive one request, then watch it to completion. With glitch=1 a second
    // request is pulsed while the first is busy; it must be ignored.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input bit glitch);
        exp_t e, g;
        logic [31:0] old;
        int cyc, nrd, nwr;
        bit seen;
        e.err = m_bad(sz, a);
        e.widx = {2'b00, a[31:2]};
        e.nrd = 0; e.nwr = 0; e.lat = 1; e.rdata = last_rdata; e.wword = '0;
        if (!e.err) begin
            old = ref_mem[a[9:2]];
            if (!w) begin
                e.nrd = 1; e.lat = 2; e.rdata = m_load(old, sz, a, sx);
            end else if (sz == 2'b10) begin
                e.nwr = 1; e.lat = 2; e.wword = wd;
                ref_mem[a[9:2]] = wd;
            end else begin
                e.nrd = 1; e.nwr = 1; e.lat = 3; e.wword = m_merge(old, sz, a, wd);
                ref_mem[a[9:2]] = e.wword;
            end
        end
        last_rdata = e.rdata;
        sb.push_back(e);

        @(negedge clock);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(negedge clock);
        // Scramble the inputs so only the captured copies can be used.
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        cyc = 1; nrd = 0; nwr = 0; seen = 1'b0;
        while (!seen && cyc <= 8) begin
            if (MemRead) nrd++;
            if (MemWrite) begin
                nwr++;
                check("write_data", WriteData, e.wword);
            end
            if (MemRead || MemWrite) check("mem_address", Address, e.widx);
            check("busy_high", {31'b0, busy}, 32'd1);
            if (glitch && cyc == 1) begin
                req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hBAD0BAD0;
            end else begin
                req = 1'b0;
            end
            if (done) seen = 1'b1;
            else begin
                cyc++;
                @(negedge clock);
            end
        end
        req = 1'b0;
        g = sb.pop_front();
        check("done_seen", {31'b0, seen}, 32'd1);
        check("latency", cyc, g.lat);
        check("err", {31'b0, err}, {31'b0, g.err});
        check("rdata", rdata, g.rdata);
        check("read_cycles", nrd, g.nrd);
        check("write_cycles", nwr, g.nwr);
    endtask

    initial begin
        int extra;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        last_rdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_memread", {31'b0, MemRead}, 32'd0);
        check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        check("rst_address", Address, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // Word store then word load.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

        // Byte/half read-modify-write stores.
        bd_write(8'd4, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        bd_write(8'd5, 32'h01234567);
        issue(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFFBEEF, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h123456C3, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);

        // Lane extraction and extension.
        bd_write(8'd4, 32'h80FF7F01);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0);

        // Highest valid word.
        bd_write(8'd255, 32'hA5A5A5A5);
        issue(1'b1, 2'b00, 1'b0, 32'h3FF, 32'h0000003C, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0);

        // Rejected requests: rdata must keep the last load value.
        issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 1'b0);

        // Request pulsed while busy is ignored.
        bd_write(8'd8, 32'h55555555);
        bd_write(8'd7, 32'h00000000);
        issue(1'b1, 2'b00, 1'b0, 32'h1F, 32'h00000077, 1'b1);
        extra = 0;
        repeat (4) begin
            @(negedge clock);
            if (done) extra++;
        end
        check("no_extra_done", extra, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 1'b0);

        // Reset during RMW_WR: write lands, no done, back to IDLE.
        bd_write(8'd6, 32'hCAFEF00D);
        ref_mem[6] = m_merge(32'hCAFEF00D, 2'b00, 32'h19, 32'h5A);
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h19; wdata = 32'h5A;
        @(negedge clock);
        req = 1'b0;
        check("rst_mid_rd", {31'b0, MemRead}, 32'd1);
        @(negedge clock);
        check("rst_mid_wr", {31'b0, MemWrite}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_rdata = '0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        extra = 0;
        if (done) extra++;
        repeat (3) begin
            @(negedge clock);
            if (done) extra++;
        end
        check("rst_mid_no_done", extra, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
